// File: rtl/tlb_array_if.sv
// Bus bundle for tlb_array: two search ports, TLBWI write, TLBR read and TLBP probe.
// The DUT side uses the slave modport; the requester (pipeline or bench) uses master.
interface tlb_array_if #(parameter int TLBNUM = 16);
  localparam int IW = $clog2(TLBNUM);

  logic [18:0]   s0_vpn2;
  logic          s0_odd_page;
  logic [7:0]    s0_asid;
  logic          s0_found;
  logic [IW-1:0] s0_index;
  logic [19:0]   s0_pfn;
  logic [2:0]    s0_c;
  logic          s0_d;
  logic          s0_v;

  logic [18:0]   s1_vpn2;
  logic          s1_odd_page;
  logic [7:0]    s1_asid;
  logic          s1_found;
  logic [IW-1:0] s1_index;
  logic [19:0]   s1_pfn;
  logic [2:0]    s1_c;
  logic          s1_d;
  logic          s1_v;

  logic          we;
  logic [IW-1:0] w_index;
  logic [18:0]   w_vpn2;
  logic [7:0]    w_asid;
  logic          w_g;
  logic [19:0]   w_pfn0, w_pfn1;
  logic [2:0]    w_c0, w_c1;
  logic          w_d0, w_d1, w_v0, w_v1;

  logic [IW-1:0] r_index;
  logic [18:0]   r_vpn2;
  logic [7:0]    r_asid;
  logic          r_g;
  logic [19:0]   r_pfn0, r_pfn1;
  logic [2:0]    r_c0, r_c1;
  logic          r_d0, r_d1, r_v0, r_v1;

  logic          tlbp_req;
  logic [31:0]   tlbp_entryhi;
  logic [IW+1:0] tlbp_result;
  logic          tlbp_busy;

  modport master (
    output s0_vpn2, s0_odd_page, s0_asid,
    input  s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v,
    output s1_vpn2, s1_odd_page, s1_asid,
    input  s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v,
    output we, w_index, w_vpn2, w_asid, w_g, w_pfn0, w_pfn1, w_c0, w_c1, w_d0, w_d1, w_v0, w_v1,
    output r_index,
    input  r_vpn2, r_asid, r_g, r_pfn0, r_pfn1, r_c0, r_c1, r_d0, r_d1, r_v0, r_v1,
    output tlbp_req, tlbp_entryhi,
    input  tlbp_result, tlbp_busy
  );

  modport slave (
    input  s0_vpn2, s0_odd_page, s0_asid,
    output s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v,
    input  s1_vpn2, s1_odd_page, s1_asid,
    output s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v,
    input  we, w_index, w_vpn2, w_asid, w_g, w_pfn0, w_pfn1, w_c0, w_c1, w_d0, w_d1, w_v0, w_v1,
    input  r_index,
    output r_vpn2, r_asid, r_g, r_pfn0, r_pfn1, r_c0, r_c1, r_d0, r_d1, r_v0, r_v1,
    input  tlbp_req, tlbp_entryhi,
    output tlbp_result, tlbp_busy
  );
endinterface

// File: rtl/tlb_array.sv
// Fully associative MIPS-style joint TLB: two combinational search ports, TLBWI/TLBR, and TLBP probe.
// Define TLB_PARALLEL_PROBE_EN for a single-cycle parallel probe; otherwise the probe scans one entry per cycle.
module tlb_array #(
  parameter int TLBNUM = 16
) (
  input logic        clk,
  input logic        resetn,
  tlb_array_if.slave bus
);
  localparam int IW = $clog2(TLBNUM);

  // Probe FSM
  // state  | meaning
  // S_IDLE | no probe since reset, result holds 0
  // S_SCAN | comparing entry r_ptr against the latched key (sequential build only)
  // S_DONE | result valid and held until next accepted request
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  logic [18:0] r_e_vpn2 [TLBNUM];
  logic [7:0]  r_e_asid [TLBNUM];
  logic        r_e_g    [TLBNUM];
  logic [19:0] r_e_pfn0 [TLBNUM];
  logic [19:0] r_e_pfn1 [TLBNUM];
  logic [2:0]  r_e_c0   [TLBNUM];
  logic [2:0]  r_e_c1   [TLBNUM];
  logic        r_e_d0   [TLBNUM];
  logic        r_e_d1   [TLBNUM];
  logic        r_e_v0   [TLBNUM];
  logic        r_e_v1   [TLBNUM];

  state_t        r_state, w_state_nxt;
  logic [IW+1:0] r_result, w_result_nxt;
  logic          w_busy;

  logic [TLBNUM-1:0] w_s0_hit, w_s1_hit;
  logic [IW-1:0]     w_s0_idx, w_s1_idx;
  logic              w_s0_found, w_s1_found;

  function automatic logic [IW-1:0] f_first(input logic [TLBNUM-1:0] hits);
    f_first = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (hits[i]) f_first = IW'(i);
    end
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < TLBNUM; i++) begin
        r_e_vpn2[i] <= '0;
        r_e_asid[i] <= '0;
        r_e_g[i]    <= 1'b0;
        r_e_pfn0[i] <= '0;
        r_e_pfn1[i] <= '0;
        r_e_c0[i]   <= '0;
        r_e_c1[i]   <= '0;
        r_e_d0[i]   <= 1'b0;
        r_e_d1[i]   <= 1'b0;
        r_e_v0[i]   <= 1'b0;
        r_e_v1[i]   <= 1'b0;
      end
    end else if (bus.we) begin
      r_e_vpn2[bus.w_index] <= bus.w_vpn2;
      r_e_asid[bus.w_index] <= bus.w_asid;
      r_e_g[bus.w_index]    <= bus.w_g;
      r_e_pfn0[bus.w_index] <= bus.w_pfn0;
      r_e_pfn1[bus.w_index] <= bus.w_pfn1;
      r_e_c0[bus.w_index]   <= bus.w_c0;
      r_e_c1[bus.w_index]   <= bus.w_c1;
      r_e_d0[bus.w_index]   <= bus.w_d0;
      r_e_d1[bus.w_index]   <= bus.w_d1;
      r_e_v0[bus.w_index]   <= bus.w_v0;
      r_e_v1[bus.w_index]   <= bus.w_v1;
    end
  end

  always_comb begin
    w_s0_hit = '0;
    w_s1_hit = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      w_s0_hit[i] = (r_e_vpn2[i] == bus.s0_vpn2) && (r_e_g[i] || (r_e_asid[i] == bus.s0_asid));
      w_s1_hit[i] = (r_e_vpn2[i] == bus.s1_vpn2) && (r_e_g[i] || (r_e_asid[i] == bus.s1_asid));
    end
  end

  assign w_s0_found = |w_s0_hit;
  assign w_s1_found = |w_s1_hit;
  assign w_s0_idx   = f_first(w_s0_hit);
  assign w_s1_idx   = f_first(w_s1_hit);

  // Miss results are forced to zero rather than exposing entry 0's fields.
  always_comb begin
    bus.s0_found = w_s0_found;
    bus.s0_index = '0;
    bus.s0_pfn   = '0;
    bus.s0_c     = '0;
    bus.s0_d     = 1'b0;
    bus.s0_v     = 1'b0;
    if (w_s0_found) begin
      bus.s0_index = w_s0_idx;
      bus.s0_pfn   = bus.s0_odd_page ? r_e_pfn1[w_s0_idx] : r_e_pfn0[w_s0_idx];
      bus.s0_c     = bus.s0_odd_page ? r_e_c1[w_s0_idx]   : r_e_c0[w_s0_idx];
      bus.s0_d     = bus.s0_odd_page ? r_e_d1[w_s0_idx]   : r_e_d0[w_s0_idx];
      bus.s0_v     = bus.s0_odd_page ? r_e_v1[w_s0_idx]   : r_e_v0[w_s0_idx];
    end
  end

  always_comb begin
    bus.s1_found = w_s1_found;
    bus.s1_index = '0;
    bus.s1_pfn   = '0;
    bus.s1_c     = '0;
    bus.s1_d     = 1'b0;
    bus.s1_v     = 1'b0;
    if (w_s1_found) begin
      bus.s1_index = w_s1_idx;
      bus.s1_pfn   = bus.s1_odd_page ? r_e_pfn1[w_s1_idx] : r_e_pfn0[w_s1_idx];
      bus.s1_c     = bus.s1_odd_page ? r_e_c1[w_s1_idx]   : r_e_c0[w_s1_idx];
      bus.s1_d     = bus.s1_odd_page ? r_e_d1[w_s1_idx]   : r_e_d0[w_s1_idx];
      bus.s1_v     = bus.s1_odd_page ? r_e_v1[w_s1_idx]   : r_e_v0[w_s1_idx];
    end
  end

  assign bus.r_vpn2 = r_e_vpn2[bus.r_index];
  assign bus.r_asid = r_e_asid[bus.r_index];
  assign bus.r_g    = r_e_g[bus.r_index];
  assign bus.r_pfn0 = r_e_pfn0[bus.r_index];
  assign bus.r_pfn1 = r_e_pfn1[bus.r_index];
  assign bus.r_c0   = r_e_c0[bus.r_index];
  assign bus.r_c1   = r_e_c1[bus.r_index];
  assign bus.r_d0   = r_e_d0[bus.r_index];
  assign bus.r_d1   = r_e_d1[bus.r_index];
  assign bus.r_v0   = r_e_v0[bus.r_index];
  assign bus.r_v1   = r_e_v1[bus.r_index];

`ifdef TLB_PARALLEL_PROBE_EN
  logic [TLBNUM-1:0] w_p_hit;

  always_comb begin
    w_p_hit = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      w_p_hit[i] = (r_e_vpn2[i] == bus.tlbp_entryhi[31:13]) &&
                   (r_e_g[i] || (r_e_asid[i] == bus.tlbp_entryhi[7:0]));
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_result <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_result <= w_result_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_result_nxt = r_result;
    w_busy       = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.tlbp_req) begin
          w_result_nxt = {1'b1, |w_p_hit, f_first(w_p_hit)};
          w_state_nxt  = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end
`else
  logic [IW-1:0] r_ptr, w_ptr_nxt;
  logic [18:0]   r_key_vpn2;
  logic [7:0]    r_key_asid;
  logic          w_key_ld;
  logic          w_scan_hit;

  // Compares live entry contents so a write landing mid-scan is seen by entries not yet visited.
  assign w_scan_hit = (r_e_vpn2[r_ptr] == r_key_vpn2) &&
                      (r_e_g[r_ptr] || (r_e_asid[r_ptr] == r_key_asid));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_result   <= '0;
      r_ptr      <= '0;
      r_key_vpn2 <= '0;
      r_key_asid <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_result <= w_result_nxt;
      r_ptr    <= w_ptr_nxt;
      if (w_key_ld) begin
        r_key_vpn2 <= bus.tlbp_entryhi[31:13];
        r_key_asid <= bus.tlbp_entryhi[7:0];
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_result_nxt = r_result;
    w_ptr_nxt    = r_ptr;
    w_key_ld     = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.tlbp_req) begin
          w_key_ld             = 1'b1;
          w_result_nxt[IW+1]   = 1'b0;
          w_ptr_nxt            = '0;
          w_state_nxt          = S_SCAN;
        end
      end
      S_SCAN: begin
        w_busy = 1'b1;
        if (w_scan_hit) begin
          w_result_nxt = {2'b11, r_ptr};
          w_ptr_nxt    = '0;
          w_state_nxt  = S_DONE;
        end else if (r_ptr == IW'(TLBNUM - 1)) begin
          w_result_nxt = {2'b10, {IW{1'b0}}};
          w_ptr_nxt    = '0;
          w_state_nxt  = S_DONE;
        end else begin
          w_ptr_nxt = r_ptr + IW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end
`endif

  assign bus.tlbp_result = r_result;
  assign bus.tlbp_busy   = w_busy;
endmodule

// File: tb/tb_tlb_array.sv
// Directed bench for tlb_array: search/read/write ports, probe latency, duplicates, ignored request, reset mid-scan.
module tb_tlb_array;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

`ifdef TLB_PARALLEL_PROBE_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  tlb_array_if bus ();
  tlb_array dut (.clk(clk), .resetn(resetn), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] idx, input logic [18:0] vpn2, input logic [7:0] asid,
                    input logic g, input logic [19:0] pfn0, input logic [19:0] pfn1,
                    input logic [2:0] c0, input logic [2:0] c1, input logic d0, input logic d1);
    bus.we = 1'b1; bus.w_index = idx; bus.w_vpn2 = vpn2; bus.w_asid = asid; bus.w_g = g;
    bus.w_pfn0 = pfn0; bus.w_pfn1 = pfn1; bus.w_c0 = c0; bus.w_c1 = c1;
    bus.w_d0 = d0; bus.w_d1 = d1; bus.w_v0 = 1'b1; bus.w_v1 = 1'b1;
    step();
    bus.we = 1'b0;
  endtask

  // Pulse a request, optionally re-pulse at scan cycle ign_at, then check latency and result.
  task automatic probe(input string tag, input logic [31:0] hi, input int lat,
                       input logic [5:0] exp, input int ign_at, input logic [31:0] hi2);
    bus.tlbp_entryhi = hi;
    bus.tlbp_req = 1'b1;
    step();
    bus.tlbp_req = 1'b0;
    for (int k = 1; k < lat; k++) begin
      chk({tag, "_scan"}, 32'({bus.tlbp_result[5], bus.tlbp_busy}), 32'b01);
      if (k == ign_at) begin
        bus.tlbp_req = 1'b1;
        bus.tlbp_entryhi = hi2;
      end
      step();
      bus.tlbp_req = 1'b0;
    end
    chk({tag, "_res"}, 32'(bus.tlbp_result), 32'(exp));
    chk({tag, "_busy"}, 32'(bus.tlbp_busy), 32'd0);
    step();
    chk({tag, "_held"}, 32'(bus.tlbp_result), 32'(exp));
  endtask

  initial begin
    bus.s0_vpn2 = '0; bus.s0_odd_page = 1'b0; bus.s0_asid = '0;
    bus.s1_vpn2 = '0; bus.s1_odd_page = 1'b0; bus.s1_asid = '0;
    bus.we = 1'b0; bus.w_index = '0; bus.w_vpn2 = '0; bus.w_asid = '0; bus.w_g = 1'b0;
    bus.w_pfn0 = '0; bus.w_pfn1 = '0; bus.w_c0 = '0; bus.w_c1 = '0;
    bus.w_d0 = 1'b0; bus.w_d1 = 1'b0; bus.w_v0 = 1'b0; bus.w_v1 = 1'b0;
    bus.r_index = '0; bus.tlbp_req = 1'b0; bus.tlbp_entryhi = '0;

    #12;
    chk("rst_result", 32'(bus.tlbp_result), 32'h00);
    chk("rst_busy", 32'(bus.tlbp_busy), 32'd0);
    resetn = 1'b1;
    step();

    bus.s0_vpn2 = 19'h0; bus.s0_asid = 8'h0; bus.s1_vpn2 = 19'h1; bus.s1_asid = 8'h0;
    #1;
    chk("rst_s0", 32'({bus.s0_found, bus.s0_index, bus.s0_pfn}), 32'({1'b1, 4'h0, 20'h0}));
    chk("rst_s1", 32'({bus.s1_found, bus.s1_index, bus.s1_pfn, bus.s1_c, bus.s1_d, bus.s1_v}), 32'h0);

    for (int i = 0; i < 16; i++)
      wr(4'(i), 19'h01000 + 19'(i), 8'h20 + 8'(i), 1'b0, 20'h00100 + 20'(i), 20'h00200 + 20'(i),
         3'd2, 3'd3, 1'b0, 1'b1);

    wr(4'd5, 19'h12345, 8'h03, 1'b0, 20'hABCDE, 20'h11111, 3'd3, 3'd5, 1'b1, 1'b0);
    bus.r_index = 4'd5;
    #1;
    chk("rd_tag", 32'({bus.r_vpn2, bus.r_asid, bus.r_g}), 32'({19'h12345, 8'h03, 1'b0}));
    chk("rd_pfn0", 32'(bus.r_pfn0), 32'hABCDE);
    chk("rd_pfn1", 32'(bus.r_pfn1), 32'h11111);
    chk("rd_flags", 32'({bus.r_c0, bus.r_c1, bus.r_d0, bus.r_d1, bus.r_v0, bus.r_v1}),
        32'({3'd3, 3'd5, 1'b1, 1'b0, 1'b1, 1'b1}));

    bus.s1_vpn2 = 19'h12345; bus.s1_asid = 8'h03; bus.s1_odd_page = 1'b1;
    bus.s0_vpn2 = 19'h12345; bus.s0_asid = 8'h03; bus.s0_odd_page = 1'b0;
    #1;
    chk("s1_odd", 32'({bus.s1_found, bus.s1_index, bus.s1_pfn}), 32'({1'b1, 4'd5, 20'h11111}));
    chk("s1_odd_cdv", 32'({bus.s1_c, bus.s1_d, bus.s1_v}), 32'({3'd5, 1'b0, 1'b1}));
    chk("s0_even", 32'({bus.s0_found, bus.s0_index, bus.s0_pfn}), 32'({1'b1, 4'd5, 20'hABCDE}));
    chk("s0_even_cdv", 32'({bus.s0_c, bus.s0_d, bus.s0_v}), 32'({3'd3, 1'b1, 1'b1}));
    bus.s1_asid = 8'h04;
    #1;
    chk("s1_asid_miss", 32'({bus.s1_found, bus.s1_index, bus.s1_pfn}), 32'h0);

    // Global rewrite: old contents must still be visible until the edge.
    bus.s1_asid = 8'h77;
    bus.we = 1'b1; bus.w_index = 4'd5; bus.w_vpn2 = 19'h12345; bus.w_asid = 8'h03; bus.w_g = 1'b1;
    bus.w_pfn0 = 20'hABCDE; bus.w_pfn1 = 20'h11111;
    #1;
    chk("g_before_edge", 32'(bus.s1_found), 32'd0);
    step();
    bus.we = 1'b0;
    chk("g_hit", 32'({bus.s1_found, bus.s1_index, bus.s1_pfn}), 32'({1'b1, 4'd5, 20'h11111}));

    wr(4'd9, 19'h00400, 8'h10, 1'b0, 20'h00900, 20'h00901, 3'd1, 3'd1, 1'b0, 1'b0);
    probe("p_hit9", 32'h0080_0010, PAR ? 1 : 11, 6'h39, 0, 32'h0);
    probe("p_miss", 32'h0FFF_E000, PAR ? 1 : 17, 6'h20, 0, 32'h0);
`ifndef TLB_PARALLEL_PROBE_EN
    probe("p_ignore", 32'h0080_0010, 11, 6'h39, 4, 32'h0FFF_E000);
`endif

    wr(4'd2, 19'h05555, 8'h44, 1'b0, 20'h00222, 20'h00223, 3'd0, 3'd0, 1'b0, 1'b0);
    wr(4'd7, 19'h05555, 8'h44, 1'b0, 20'h00777, 20'h00778, 3'd0, 3'd0, 1'b0, 1'b0);
    bus.s0_vpn2 = 19'h05555; bus.s0_asid = 8'h44; bus.s0_odd_page = 1'b0;
    #1;
    chk("dup_s0", 32'({bus.s0_found, bus.s0_index, bus.s0_pfn}), 32'({1'b1, 4'd2, 20'h00222}));
    probe("p_dup", {19'h05555, 5'h0, 8'h44}, PAR ? 1 : 4, 6'h32, 0, 32'h0);

    // Reset dropped at cycle N+4 of a scan.
    bus.tlbp_entryhi = 32'h0080_0010;
    bus.tlbp_req = 1'b1;
    step();
    bus.tlbp_req = 1'b0;
    step(); step(); step();
    resetn = 1'b0;
    #1;
    chk("mid_rst_result", 32'(bus.tlbp_result), 32'h00);
    chk("mid_rst_busy", 32'(bus.tlbp_busy), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    step();
    bus.s0_vpn2 = 19'h0; bus.s0_asid = 8'h0;
    #1;
    chk("post_rst_s0", 32'({bus.s0_found, bus.s0_index, bus.s0_pfn}), 32'({1'b1, 4'h0, 20'h0}));
    probe("p_after_rst", 32'h0, PAR ? 1 : 2, 6'h30, 0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
